// File: rtl/core_mc.sv
`default_nettype none
// =============================================================================
// core_mc : multi-cycle RV32I/RV64I core top (fetch / execute / memory / wb)
// Optional macro: CORE_MC_EBREAK_HALT_EN -- ebreak parks the core in HALT.
// Revision: 1.0
// =============================================================================
module core_mc #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            ifu_req_valid,
   input  logic            ifu_req_ready,
   output logic [XLEN-1:0] ifu_req_addr,
   input  logic            ifu_rsp_valid,
   input  logic [31:0]     ifu_rsp_data,
   output logic            lsu_req_valid,
   input  logic            lsu_req_ready,
   output logic [XLEN-1:0] lsu_req_addr,
   output logic [XLEN-1:0] lsu_req_wdata,
   output logic            lsu_req_wr,
   output logic [2:0]      lsu_req_op,
   input  logic            lsu_rsp_valid,
   input  logic [XLEN-1:0] lsu_rsp_rdata,
   output logic [XLEN-1:0] pc_o,
   output logic            commit_valid,
   output logic [6:0]      opcode_o,
   output logic [XLEN-1:0] reg_a0,
   output logic            halted
);
   typedef enum logic [2:0] {IF_REQ, IF_WAIT, EX, MEM_REQ, MEM_WAIT, WB, HALT} state_t;
   localparam int SHW = $clog2(XLEN);

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, alu_q, alu_d, rs2_q, rs2_d, npc_q, npc_d, mem_q, mem_d;
   logic [31:0]     instr_q, instr_d;
   logic [2:0]      op_q, op_d;
   logic            wr_q, wr_d, ifv_q, ifv_d, lsv_q, lsv_d, commit_q, commit_d, halt_q, halt_d;
   logic [XLEN-1:0] rf_q [32];

   logic [6:0]      opc;
   logic [4:0]      rd, rs1, rs2;
   logic [2:0]      f3, alu_fn;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, pc_imm;
   logic [XLEN-1:0] rs1_v, rs2_v, op_a, op_b, sh_a, alu_res, rf_wdata;
   logic [SHW-1:0]  shamt;
   logic            alu_alt, reg_wr_en, dwsel, word, pca_src, pcb_src, is_ld, is_st, br_take;

   assign opc = instr_q[6:0];
   assign rd  = instr_q[11:7];
   assign f3  = instr_q[14:12];
   assign rs1 = instr_q[19:15];
   assign rs2 = instr_q[24:20];

   assign imm_i = XLEN'($signed(instr_q[31:20]));
   assign imm_s = XLEN'($signed({instr_q[31:25], instr_q[11:7]}));
   assign imm_b = XLEN'($signed({instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({instr_q[31:12], 12'b0}));
   assign imm_j = XLEN'($signed({instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0}));

   assign rs1_v = (rs1 == 5'd0) ? '0 : rf_q[rs1];
   assign rs2_v = (rs2 == 5'd0) ? '0 : rf_q[rs2];

   always_comb begin
      case (f3)
         3'b000:  br_take = (rs1_v == rs2_v);
         3'b001:  br_take = (rs1_v != rs2_v);
         3'b100:  br_take = ($signed(rs1_v) < $signed(rs2_v));
         3'b101:  br_take = ($signed(rs1_v) >= $signed(rs2_v));
         3'b110:  br_take = (rs1_v < rs2_v);
         3'b111:  br_take = (rs1_v >= rs2_v);
         default: br_take = 1'b0;
      endcase
   end

   // Decode: JAL/JALR compute the link value pc+4 through the ALU.
   always_comb begin
      pc_imm    = imm_b;
      pca_src   = 1'b0;
      pcb_src   = 1'b0;
      op_a      = rs1_v;
      op_b      = imm_i;
      alu_fn    = 3'b000;
      alu_alt   = 1'b0;
      reg_wr_en = 1'b0;
      dwsel     = 1'b0;
      is_ld     = 1'b0;
      is_st     = 1'b0;
      case (opc)
         7'b0110111: begin op_a = '0; op_b = imm_u; reg_wr_en = 1'b1; end
         7'b0010111: begin op_a = pc_q; op_b = imm_u; reg_wr_en = 1'b1; end
         7'b1101111: begin
            op_a = pc_q; op_b = XLEN'(4); pc_imm = imm_j; pca_src = 1'b1; reg_wr_en = 1'b1;
         end
         7'b1100111: begin
            op_a = pc_q; op_b = XLEN'(4); pc_imm = imm_i; pca_src = 1'b1; pcb_src = 1'b1;
            reg_wr_en = 1'b1;
         end
         7'b1100011: pca_src = br_take;
         7'b0000011: begin is_ld = 1'b1; reg_wr_en = 1'b1; end
         7'b0100011: begin op_b = imm_s; is_st = 1'b1; end
         7'b0010011, 7'b0011011: begin
            alu_fn = f3; alu_alt = (f3 == 3'b101) & instr_q[30]; reg_wr_en = 1'b1; dwsel = opc[3];
         end
         7'b0110011, 7'b0111011: begin
            op_b = rs2_v; alu_fn = f3; alu_alt = instr_q[30]; reg_wr_en = 1'b1; dwsel = opc[3];
         end
         default: ;
      endcase
   end

   assign word  = dwsel & (XLEN == 64);
   assign shamt = word ? SHW'(op_b[4:0]) : op_b[SHW-1:0];
   assign sh_a  = word ? (alu_alt ? XLEN'($signed(op_a[31:0])) : XLEN'(op_a[31:0])) : op_a;

   always_comb begin
      case (alu_fn)
         3'b000:  alu_res = alu_alt ? (op_a - op_b) : (op_a + op_b);
         3'b001:  alu_res = op_a << shamt;
         3'b010:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
         3'b011:  alu_res = XLEN'(op_a < op_b);
         3'b100:  alu_res = op_a ^ op_b;
         3'b101:  alu_res = alu_alt ? XLEN'($signed(sh_a) >>> shamt) : (sh_a >> shamt);
         3'b110:  alu_res = op_a | op_b;
         default: alu_res = op_a & op_b;
      endcase
   end

   assign rf_wdata = is_ld ? mem_q : (word ? XLEN'($signed(alu_q[31:0])) : alu_q);

   // Architectural registers deliberately have no reset.
   always_ff @(posedge clk) begin
      if (state_q == WB && reg_wr_en && rd != 5'd0) rf_q[rd] <= rf_wdata;
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      alu_d    = alu_q;
      rs2_d    = rs2_q;
      npc_d    = npc_q;
      mem_d    = mem_q;
      wr_d     = wr_q;
      op_d     = op_q;
      case (state_q)
         IF_REQ:   if (ifv_q && ifu_req_ready) state_d = IF_WAIT;
         IF_WAIT:  if (ifu_rsp_valid) begin instr_d = ifu_rsp_data; state_d = EX; end
         EX: begin
            alu_d   = alu_res;
            rs2_d   = rs2_v;
            npc_d   = (pca_src ? pc_imm : XLEN'(4)) + (pcb_src ? rs1_v : pc_q);
            wr_d    = is_st;
            op_d    = f3;
            state_d = (is_ld | is_st) ? MEM_REQ : WB;
`ifdef CORE_MC_EBREAK_HALT_EN
            if (instr_q == 32'h0010_0073) state_d = HALT;
`endif
         end
         MEM_REQ:  if (lsv_q && lsu_req_ready) state_d = MEM_WAIT;
         MEM_WAIT: if (lsu_rsp_valid) begin mem_d = lsu_rsp_rdata; state_d = WB; end
         WB:       begin pc_d = npc_q; state_d = IF_REQ; end
         HALT:     ;
         default:  state_d = IF_REQ;
      endcase
      // Handshake outputs are registered images of the next state.
      ifv_d    = (state_d == IF_REQ);
      lsv_d    = (state_d == MEM_REQ);
      commit_d = (state_d == WB);
      halt_d   = (state_d == HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IF_REQ;
         pc_q     <= RESET_PC;
         instr_q  <= '0;
         alu_q    <= '0;
         rs2_q    <= '0;
         npc_q    <= '0;
         mem_q    <= '0;
         wr_q     <= 1'b0;
         op_q     <= '0;
         ifv_q    <= 1'b0;
         lsv_q    <= 1'b0;
         commit_q <= 1'b0;
         halt_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         alu_q    <= alu_d;
         rs2_q    <= rs2_d;
         npc_q    <= npc_d;
         mem_q    <= mem_d;
         wr_q     <= wr_d;
         op_q     <= op_d;
         ifv_q    <= ifv_d;
         lsv_q    <= lsv_d;
         commit_q <= commit_d;
         halt_q   <= halt_d;
      end
   end

   assign ifu_req_valid = ifv_q;
   assign ifu_req_addr  = pc_q;
   assign lsu_req_valid = lsv_q;
   assign lsu_req_addr  = alu_q;
   assign lsu_req_wdata = rs2_q;
   assign lsu_req_wr    = wr_q;
   assign lsu_req_op    = op_q;
   assign pc_o          = pc_q;
   assign commit_valid  = commit_q;
   assign opcode_o      = instr_q[6:0];
   assign reg_a0        = rf_q[10];
   assign halted        = halt_q;
endmodule
`default_nettype wire

// File: tb/tb_core_mc.sv
`timescale 1ns/1ps
`default_nettype none
// Directed program bench for core_mc with memory responders and a commit scoreboard.
module tb_core_mc;
   localparam int              XLEN     = 64;
   localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
   logic [XLEN-1:0] ifu_req_addr;
   logic [31:0]     ifu_rsp_data;
   logic            lsu_req_valid, lsu_req_ready, lsu_req_wr, lsu_rsp_valid;
   logic [XLEN-1:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_rdata;
   logic [2:0]      lsu_req_op;
   logic [XLEN-1:0] pc_o, reg_a0;
   logic            commit_valid, halted;
   logic [6:0]      opcode_o;

   core_mc #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
      .lsu_req_wdata(lsu_req_wdata), .lsu_req_wr(lsu_req_wr), .lsu_req_op(lsu_req_op),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
      .pc_o(pc_o), .commit_valid(commit_valid), .opcode_o(opcode_o), .reg_a0(reg_a0),
      .halted(halted)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0]     imem [logic [63:0]];
   logic [63:0]     dmem [logic [63:0]];
   int              if_wait = -1, if_stall = 0, ls_wait = -1, ls_delay = 0;
   logic [63:0]     if_addr, if_stall_addr, ls_addr;

   typedef struct { logic [63:0] pc; int cyc; logic [63:0] a0; } exp_t;
   exp_t sbq[$];
   int   errors = 0, checks = 0, base = 0;

   function automatic logic [31:0] imem_rd(input logic [63:0] a);
      return imem.exists(a) ? imem[a] : 32'h0000_0013;
   endfunction

   function automatic logic [63:0] dmem_rd(input logic [63:0] a);
      return dmem.exists(a) ? dmem[a] : 64'd0;
   endfunction

   // Bus responders: drive #1 after each rising edge, response at least one cycle after handshake.
   initial begin
      ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_data = '0;
      lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0; lsu_rsp_rdata = '0;
      forever begin
         @(posedge clk); #1;
         ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0;
         lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
         if (!rst_n) begin
            if_wait = -1; ls_wait = -1;
         end else begin
            if (if_wait == 0) begin
               ifu_rsp_valid = 1'b1; ifu_rsp_data = imem_rd(if_addr); if_wait = -1;
            end else if (if_wait > 0) if_wait--;
            if (ifu_req_valid && if_wait < 0) begin
               if (if_stall > 0 && ifu_req_addr == if_stall_addr) if_stall--;
               else begin ifu_req_ready = 1'b1; if_wait = 0; if_addr = ifu_req_addr; end
            end
            if (ls_wait == 0) begin
               lsu_rsp_valid = 1'b1; lsu_rsp_rdata = dmem_rd(ls_addr); ls_wait = -1;
            end else if (ls_wait > 0) ls_wait--;
            if (lsu_req_valid && ls_wait < 0) begin
               lsu_req_ready = 1'b1; ls_wait = ls_delay; ls_addr = lsu_req_addr;
               if (lsu_req_wr) dmem[lsu_req_addr] = lsu_req_wdata;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [63:0] pc, input int c, input logic [63:0] a0);
      exp_t e;
      e.pc = pc; e.cyc = c; e.a0 = a0;
      sbq.push_back(e);
   endtask

   task automatic wait_commit(input string tag);
      exp_t e;
      logic seen;
      e = sbq.pop_front();
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (commit_valid) seen = 1'b1;
      end
      chk({tag, " commit seen"}, 64'(seen), 64'd1);
      chk({tag, " pc"}, pc_o, e.pc);
      chk({tag, " cycle"}, 64'(cyc - base), 64'(e.cyc));
      @(negedge clk);
      chk({tag, " a0"}, reg_a0, e.a0);
      chk({tag, " commit pulse"}, 64'(commit_valid), 64'd0);
   endtask

   task automatic release_reset();
      rst_n = 1'b1;
      @(negedge clk);
      chk("first fetch valid", 64'(ifu_req_valid), 64'd1);
      chk("first fetch addr", ifu_req_addr, RESET_PC);
      base = cyc;
   endtask

   initial begin
      imem[RESET_PC + 64'h00] = 32'h0050_0513;   // addi a0,x0,5
      imem[RESET_PC + 64'h04] = 32'hFF95_0513;   // addi a0,a0,-7
      imem[RESET_PC + 64'h08] = 32'h0035_0513;   // addi a0,a0,3
      imem[RESET_PC + 64'h0C] = 32'h0080_3503;   // ld a0,8(x0)
      imem[RESET_PC + 64'h10] = 32'hFE00_0CE3;   // beq x0,x0,-8
      dmem[64'h8] = 64'h1122_3344_5566_7788;
      if_stall = 3; if_stall_addr = RESET_PC + 64'h08; ls_delay = 2;

      repeat (3) @(negedge clk);
      chk("rst ifu_req_addr", ifu_req_addr, RESET_PC);
      chk("rst ifu_req_valid", 64'(ifu_req_valid), 64'd0);
      chk("rst lsu_req_valid", 64'(lsu_req_valid), 64'd0);
      chk("rst commit_valid", 64'(commit_valid), 64'd0);
      chk("rst halted", 64'(halted), 64'd0);
      chk("rst opcode_o", 64'(opcode_o), 64'd0);
      chk("rst lsu_req_wr", 64'(lsu_req_wr), 64'd0);
      chk("rst pc_o", pc_o, RESET_PC);
      release_reset();

      push(RESET_PC, 3, 64'd5);
      push(RESET_PC + 64'h04, 7, 64'hFFFF_FFFF_FFFF_FFFE);
      wait_commit("addi5");
      wait_commit("addi-7");

      for (int i = 0; i < 4; i++) begin
         chk("stall valid", 64'(ifu_req_valid), 64'd1);
         chk("stall addr", ifu_req_addr, RESET_PC + 64'h08);
         if (i < 3) @(negedge clk);
      end
      push(RESET_PC + 64'h08, 14, 64'd1);
      wait_commit("stalled addi");

      push(RESET_PC + 64'h0C, 22, 64'h1122_3344_5566_7788);
      repeat (3) @(negedge clk);
      chk("ld req valid", 64'(lsu_req_valid), 64'd1);
      chk("ld req addr", lsu_req_addr, 64'd8);
      chk("ld req wr", 64'(lsu_req_wr), 64'd0);
      chk("ld req op", 64'(lsu_req_op), 64'd3);
      wait_commit("ld slow");

      ls_delay = 0;
      dmem[64'h8] = 64'h0000_0000_7FFF_FFFF;
      push(RESET_PC + 64'h10, 26, 64'h1122_3344_5566_7788);
      wait_commit("beq");
      chk("branch target addr", ifu_req_addr, RESET_PC + 64'h08);
      chk("branch target pc_o", pc_o, RESET_PC + 64'h08);
      imem[RESET_PC + 64'h10] = 32'h0015_051B;   // addiw a0,a0,1
      imem[RESET_PC + 64'h14] = 32'h0010_0073;   // ebreak
      imem[RESET_PC + 64'h18] = 32'h0100_3503;   // ld a0,16(x0)

      push(RESET_PC + 64'h08, 30, 64'h1122_3344_5566_778B);
      push(RESET_PC + 64'h0C, 36, 64'h0000_0000_7FFF_FFFF);
      push(RESET_PC + 64'h10, 40, 64'hFFFF_FFFF_8000_0000);
      wait_commit("addi again");
      wait_commit("ld fast");
      wait_commit("addiw");

`ifdef CORE_MC_EBREAK_HALT_EN
      repeat (3) @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         chk("halt status", 64'({halted, ifu_req_valid, lsu_req_valid, commit_valid}), 64'b1000);
         @(negedge clk);
      end
`else
      push(RESET_PC + 64'h14, 44, 64'hFFFF_FFFF_8000_0000);
      wait_commit("ebreak nop");
      ls_delay = 10;
      repeat (4) @(negedge clk);
      chk("mem_wait lsu valid", 64'(lsu_req_valid), 64'd0);
      chk("mem_wait opcode", 64'(opcode_o), 64'h03);
      rst_n = 1'b0;
      #1;
      chk("async rst ifu_req_addr", ifu_req_addr, RESET_PC);
      chk("async rst pc_o", pc_o, RESET_PC);
      chk("async rst opcode_o", 64'(opcode_o), 64'd0);
      chk("async rst valids", 64'({ifu_req_valid, lsu_req_valid, commit_valid, halted}), 64'd0);
      chk("async rst lsu_req_wr", 64'(lsu_req_wr), 64'd0);
      repeat (2) @(negedge clk);
      chk("no write under reset", reg_a0, 64'hFFFF_FFFF_8000_0000);
      ls_delay = 0;
      release_reset();
      push(RESET_PC, 3, 64'd5);
      wait_commit("restart addi5");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach summary");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire

// File: doc/core_mc.md
# core_mc

Multi-cycle, parametrised RV core top that replaces the single-cycle datapath with a fetch/execute/memory/writeback state machine. Instruction and data memories connect through valid/ready request-response handshakes. Decode, immediate expansion, ALU, branch condition and register file reuse the existing IDU, imm_exp, ALU, bcu and regfiles blocks. This is the top instantiated by the Verilator harness.

## Interface
- XLEN, 64, datapath width; legal values are 32 and 64.
- RESET_PC, XLEN'h80000000, PC value after reset.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- ifu_req_valid  out  1  fetch request.
- ifu_req_ready  in  1  fetch request accepted.
- ifu_req_addr  out  XLEN  fetch address (current PC).
- ifu_rsp_valid  in  1  fetch data valid.
- ifu_rsp_data  in  32  instruction word.
- lsu_req_valid  out  1  data request.
- lsu_req_ready  in  1  data request accepted.
- lsu_req_addr  out  XLEN  effective address (latched ALU result).
- lsu_req_wdata  out  XLEN  store data (rs2).
- lsu_req_wr  out  1  1 = store, 0 = load.
- lsu_req_op  out  3  MemOp from IDU (funct3 encoding).
- lsu_rsp_valid  in  1  load data valid, or store completed.
- lsu_rsp_rdata  in  XLEN  load data, already sized and extended per lsu_req_op.
- pc_o  out  XLEN  architectural PC.
- commit_valid  out  1  one-cycle pulse per retired instruction.
- opcode_o  out  7  instr_reg[6:0], for debug.
- reg_a0  out  XLEN  x10, for debug.
- halted  out  1  core stopped (see Configuration).

## Operation
- States: IF_REQ, IF_WAIT, EX, MEM_REQ, MEM_WAIT, WB, HALT.
- **IF_REQ:** ifu_req_valid=1, ifu_req_addr=pc. On valid&ready, go to IF_WAIT.
- **IF_WAIT:** on ifu_rsp_valid, latch instr_reg and go to EX. ifu_rsp_valid is ignored in every other state.
- **EX:** decode instr_reg. Read rs1/rs2. Latch alu_q (the ALU result), rs2_q, and next_pc_q = (PCAsrc ? imm : 4) + (PCBsrc ? rs1 : pc).
  - Loads and stores go to MEM_REQ.
  - All other instructions go to WB.
- **MEM_REQ:** lsu_req_valid=1, with addr/wdata/wr/op held stable until ready. On handshake, go to MEM_WAIT.
- **MEM_WAIT:** on lsu_rsp_valid, latch load data into mem_q and go to WB.
- **WB:**
  - Regfile write enable is IDU RegWrEn, gated to this state only. No writes occur in other states.
  - Write data is mem_q for loads. Otherwise it is alu_q, sign-extended from bit 31 when dwsel=1 and XLEN=64; dwsel is ignored when XLEN=32.
  - pc <= next_pc_q, commit_valid=1, then go to IF_REQ.
- Writes to x0 are discarded by regfiles.
- Widths: all PC arithmetic is modulo 2^XLEN and wraps silently. Misaligned PC or data addresses are not checked; they are passed to the bus unchanged.
- A request, once valid, is never withdrawn before ready.

## Timing
- **Reset values:** state=IF_REQ, pc=RESET_PC, instr_reg=0 (opcode_o=0), all *_valid=0, commit_valid=0, halted=0, lsu_req_wr=0.
  - The first ifu_req_valid is asserted in the first cycle after rst_n deasserts.
- Response is accepted at the earliest one cycle after the request handshake; same-cycle responses are not supported.
- **Zero-wait latency:**
  - Non-memory instruction: 4 cycles (IF_REQ, IF_WAIT, EX, WB).
  - Load/store: 6 cycles.
  - Each ready-low or rsp-low cycle adds one cycle.
- commit_valid rises in the WB cycle. pc_o takes the new value on the following edge.
- **Reset mid-operation:** returns immediately to reset values, whatever the state.
  - Any in-flight bus transaction is abandoned.
  - Memories must share rst_n so that no stale response arrives after reset.
- Registers hold their value under reset; only the PC/FSM/pipeline registers reset.

## Configuration
- Macro `CORE_MC_EBREAK_HALT_EN`:
  - **Defined:** in EX, instr_reg==32'h00100073 goes to HALT. In HALT, halted=1, no bus requests are issued and commit_valid=0. Only reset exits HALT. ebreak does not retire.
  - **Undefined:** ebreak is treated as a non-memory instruction with no register write (PC+4, retires normally). HALT is unreachable and halted is tied to 0.

## Test plan
- Reset with RESET_PC=0x80000000 -> ifu_req_addr=0x80000000 and all valids 0 during reset; ifu_req_valid=1 on the first cycle after release.
- Zero-wait program `addi a0,x0,5; addi a0,a0,-7` -> commit_valid at cycles 3 and 7; reg_a0 = XLEN'(-2).
- ifu_req_ready held low 3 cycles -> addr stable and no state advance; commit is delayed by exactly 3 cycles.
- `ld a0,8(x0)` with a 2-cycle rsp delay and rdata=0x1122334455667788 -> lsu_req_addr=8, lsu_req_wr=0, op=3'b011; a0 updated at WB; total 8 cycles.
- `beq x0,x0,-8` at PC 0x80000010 -> next ifu_req_addr=0x80000008. `addiw` producing 0x80000000 on XLEN=64 -> rd=0xFFFFFFFF80000000.
- rst_n pulsed low during MEM_WAIT -> outputs return to reset values asynchronously and no register write occurs. With `CORE_MC_EBREAK_HALT_EN`, ebreak gives halted=1 with no further requests for 20 cycles.
